// File: rtl/periferico_stdin_pkg.sv
// Shared definitions for the stdin peripheral: register addresses,
// entry width, status bit positions and the debounce FSM states.
package stdin_pkg;

    localparam logic [31:0] STDIN_DADOS  = 32'h0000_00F8;
    localparam logic [31:0] STDIN_STATUS = 32'h0000_00FC;

    localparam int LARGURA_ENTRADA = 7;

    localparam int BIT_NAO_VAZIO  = 0;
    localparam int BIT_CHEIO      = 1;
    localparam int BIT_TRANSBORDO = 2;

    typedef enum logic [1:0] {
        OCIOSO,
        FILTRANDO,
        PRESSIONADO,
        SOLTANDO
    } estado_t;

endpackage

// File: rtl/periferico_stdin_if.sv
// Load-bus and board I/O bundle of the stdin peripheral; the processor
// side uses modport master, the peripheral uses modport slave.
interface periferico_stdin_if;
    import stdin_pkg::*;

    logic [31:0]                end_lei;
    logic                       le;
    logic [31:0]                saida;
    logic                       sel_stdin;
    logic [LARGURA_ENTRADA-1:0] chaves;
    logic                       botao;
    logic                       cheio;
    logic [LARGURA_ENTRADA-1:0] eco;

    modport master (
        output end_lei, le, chaves, botao,
        input  saida, sel_stdin, cheio, eco
    );

    modport slave (
        input  end_lei, le, chaves, botao,
        output saida, sel_stdin, cheio, eco
    );

endinterface

// File: rtl/fifo_stdin.sv
// Small FIFO of switch captures; pointers and count carry one extra bit
// so full and empty are told apart by the count alone.
module fifo_stdin
    import stdin_pkg::*;
#(
    parameter int PROFUNDIDADE = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [LARGURA_ENTRADA-1:0] dado_in,
    output logic [LARGURA_ENTRADA-1:0] head,
    output logic                       cheio,
    output logic                       vazio,
    output logic                       overflow
);

    localparam int AW = $clog2(PROFUNDIDADE);

    logic [LARGURA_ENTRADA-1:0] mem [PROFUNDIDADE];
    logic [AW:0]                ptr_lei;
    logic [AW:0]                ptr_esc;
    logic [AW:0]                contagem;
    logic                       pop_ok;
    logic                       push_ok;

    assign vazio    = (contagem == '0);
    assign cheio    = (contagem == (AW+1)'(PROFUNDIDADE));
    assign pop_ok   = pop && !vazio;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push && (!cheio || pop_ok);
    assign overflow = push && !push_ok;
    assign head     = mem[ptr_lei[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_lei  <= '0;
            ptr_esc  <= '0;
            contagem <= '0;
        end else begin
            if (pop_ok)
                ptr_lei <= ptr_lei + 1'b1;
            if (push_ok)
                ptr_esc <= ptr_esc + 1'b1;
            contagem <= contagem + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[ptr_esc[AW-1:0]] <= dado_in;
    end

endmodule

// File: rtl/periferico_stdin.sv
// Memory-mapped stdin peripheral: debounced button captures the switches
// into a FIFO read at STDIN_DADOS, status at STDIN_STATUS. Optional echo
// register enabled by STDIN_ECO_EN.
module periferico_stdin
    import stdin_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int PROFUNDIDADE    = 4
) (
    input logic               clk,
    input logic               reset,
    periferico_stdin_if.slave bus
);

    localparam int             CW       = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0]  CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic [1:0]                 sincro;
    logic                       botao_s;
    estado_t                    estado;
    logic [CW-1:0]              cont;
    logic                       push;
    logic                       le_dados;
    logic                       le_status;
    logic [LARGURA_ENTRADA-1:0] head;
    logic                       cheio;
    logic                       vazio;
    logic                       overflow;
    logic                       transbordo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sincro <= '0;
        else
            sincro <= {sincro[0], bus.botao};
    end

    assign botao_s = sincro[1];
    assign push    = (estado == FILTRANDO) && botao_s && (cont == CONT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            cont   <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (botao_s) begin
                        estado <= FILTRANDO;
                        cont   <= '0;
                    end
                end
                FILTRANDO: begin
                    if (!botao_s)
                        estado <= OCIOSO;
                    else if (cont == CONT_MAX)
                        estado <= PRESSIONADO;
                    else
                        cont <= cont + 1'b1;
                end
                PRESSIONADO: begin
                    if (!botao_s) begin
                        estado <= SOLTANDO;
                        cont   <= '0;
                    end
                end
                SOLTANDO: begin
                    if (botao_s)
                        estado <= PRESSIONADO;
                    else if (cont == CONT_MAX)
                        estado <= OCIOSO;
                    else
                        cont <= cont + 1'b1;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign le_dados  = bus.le && (bus.end_lei == STDIN_DADOS);
    assign le_status = bus.le && (bus.end_lei == STDIN_STATUS);

    fifo_stdin #(
        .PROFUNDIDADE(PROFUNDIDADE)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (le_dados),
        .dado_in  (bus.chaves),
        .head     (head),
        .cheio    (cheio),
        .vazio    (vazio),
        .overflow (overflow)
    );

    // Setting has priority so an overflow coinciding with a status read is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            transbordo <= 1'b0;
        else if (overflow)
            transbordo <= 1'b1;
        else if (le_status)
            transbordo <= 1'b0;
    end

    always_comb begin
        bus.saida     = '0;
        bus.sel_stdin = 1'b0;
        if (bus.end_lei == STDIN_DADOS) begin
            bus.sel_stdin = 1'b1;
            if (!vazio)
                bus.saida = {{(32-LARGURA_ENTRADA){1'b0}}, head};
        end else if (bus.end_lei == STDIN_STATUS) begin
            bus.sel_stdin                 = 1'b1;
            bus.saida[BIT_NAO_VAZIO]  = !vazio;
            bus.saida[BIT_CHEIO]      = cheio;
            bus.saida[BIT_TRANSBORDO] = transbordo;
        end
    end

    assign bus.cheio = cheio;

`ifdef STDIN_ECO_EN
    logic [LARGURA_ENTRADA-1:0] eco_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            eco_reg <= '0;
        else if (push && !overflow)
            eco_reg <= bus.chaves;
    end

    assign bus.eco = eco_reg;
`else
    assign bus.eco = '0;
`endif

endmodule

// File: tb/tb_periferico_stdin.sv
// Directed self-checking bench for periferico_stdin (DEBOUNCE_CICLOS=4,
// PROFUNDIDADE=4); echo checks follow STDIN_ECO_EN.
module tb_periferico_stdin;
    import stdin_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks_total  = 0;
    int   checks_passed = 0;

    always #5 clk = ~clk;

    periferico_stdin_if bus ();

    periferico_stdin #(
        .DEBOUNCE_CICLOS (4),
        .PROFUNDIDADE    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observado, input logic [31:0] esperado);
        checks_total++;
        if (observado === esperado)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observado, esperado);
    endtask

    task automatic checkEco(input string tag, input logic [6:0] valor);
`ifdef STDIN_ECO_EN
        checkOutput(tag, {25'b0, bus.eco}, {25'b0, valor});
`else
        checkOutput(tag, {25'b0, bus.eco}, 32'h0);
`endif
    endtask

    // Called just after a negedge; leaves the bus idle one cycle later.
    task automatic readRegister(input logic [31:0] addr, input logic [31:0] esperado, input string tag);
        bus.end_lei = addr;
        bus.le      = 1'b1;
        #1;
        checkOutput(tag, bus.saida, esperado);
        @(negedge clk);
        bus.le      = 1'b0;
        bus.end_lei = 32'h0;
    endtask

    task automatic applyStimulus(input logic [6:0] valor);
        bus.chaves = valor;
        bus.botao  = 1'b1;
        repeat (10) @(negedge clk);
        bus.botao  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        bus.botao   = 1'b0;
        bus.le      = 1'b0;
        bus.end_lei = 32'h0;
        bus.chaves  = 7'h0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_cheio", {31'b0, bus.cheio}, 32'h0);
        checkEco("reset_eco", 7'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        bus.end_lei = STDIN_STATUS;
        #1;
        checkOutput("sel_status", {31'b0, bus.sel_stdin}, 32'h1);
        bus.end_lei = STDIN_DADOS;
        #1;
        checkOutput("sel_dados", {31'b0, bus.sel_stdin}, 32'h1);
        bus.end_lei = 32'h0000_00F4;
        #1;
        checkOutput("sel_unmapped", {31'b0, bus.sel_stdin}, 32'h0);
        checkOutput("saida_unmapped", bus.saida, 32'h0);
        @(negedge clk);
        readRegister(STDIN_STATUS, 32'h0, "status_after_reset");
        readRegister(STDIN_DADOS, 32'h0, "data_empty");
        readRegister(STDIN_STATUS, 32'h0, "status_no_pop");

        // Press latency: push lands exactly on edge 7.
        bus.chaves = 7'h2A;
        bus.botao  = 1'b1;
        repeat (6) @(negedge clk);
        bus.end_lei = STDIN_STATUS;
        #1;
        checkOutput("status_edge6", bus.saida, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("status_edge7", bus.saida, 32'h1);
        repeat (3) @(negedge clk);
        bus.botao = 1'b0;
        repeat (10) @(negedge clk);
        readRegister(STDIN_STATUS, 32'h1, "status_one_push");
        checkEco("eco_2a", 7'h2A);
        readRegister(STDIN_DADOS, 32'h2A, "data_2a");
        readRegister(STDIN_STATUS, 32'h0, "status_after_pop");

        // Short glitch never reaches the push.
        bus.chaves = 7'h55;
        bus.botao  = 1'b1;
        repeat (3) @(negedge clk);
        bus.botao  = 1'b0;
        repeat (10) @(negedge clk);
        readRegister(STDIN_STATUS, 32'h0, "status_glitch");

        // Release bounce while held yields a single push.
        bus.chaves = 7'h11;
        bus.botao  = 1'b1;
        repeat (10) @(negedge clk);
        bus.botao  = 1'b0;
        repeat (2) @(negedge clk);
        bus.botao  = 1'b1;
        repeat (5) @(negedge clk);
        bus.botao  = 1'b0;
        repeat (10) @(negedge clk);
        readRegister(STDIN_STATUS, 32'h1, "status_bounce");
        readRegister(STDIN_DADOS, 32'h11, "data_bounce");
        readRegister(STDIN_DADOS, 32'h0, "data_bounce_empty");

        // Five presses into a depth-4 FIFO: last one overflows.
        for (int i = 1; i <= 5; i++)
            applyStimulus(7'(i));
        #1;
        checkOutput("cheio_overflow", {31'b0, bus.cheio}, 32'h1);
        checkEco("eco_overflow", 7'h4);
        readRegister(STDIN_STATUS, 32'h7, "status_overflow");
        readRegister(STDIN_STATUS, 32'h3, "status_cleared");
        for (int i = 1; i <= 4; i++)
            readRegister(STDIN_DADOS, 32'(i), $sformatf("data_ovf_%0d", i));
        readRegister(STDIN_DADOS, 32'h0, "data_ovf_empty");
        readRegister(STDIN_STATUS, 32'h0, "status_ovf_empty");

        // Push coinciding with a pop while full.
        for (int i = 0; i < 4; i++)
            applyStimulus(7'(8'h0A + i));
        readRegister(STDIN_STATUS, 32'h3, "status_full");
        bus.chaves = 7'h0E;
        bus.botao  = 1'b1;
        repeat (6) @(negedge clk);
        bus.end_lei = STDIN_DADOS;
        bus.le      = 1'b1;
        #1;
        checkOutput("head_before_swap", bus.saida, 32'h0A);
        @(negedge clk);
        bus.le      = 1'b0;
        bus.end_lei = STDIN_STATUS;
        #1;
        checkOutput("status_swap", bus.saida, 32'h3);
        checkOutput("cheio_swap", {31'b0, bus.cheio}, 32'h1);
        checkEco("eco_swap", 7'h0E);
        repeat (3) @(negedge clk);
        bus.botao = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++)
            readRegister(STDIN_DADOS, 32'(8'h0B + i), $sformatf("data_swap_%0d", i));
        readRegister(STDIN_DADOS, 32'h0, "data_swap_empty");

        // Reset with entries pending and the FSM mid-filter.
        applyStimulus(7'h21);
        applyStimulus(7'h22);
        readRegister(STDIN_STATUS, 32'h1, "status_pending");
        bus.chaves = 7'h23;
        bus.botao  = 1'b1;
        repeat (4) @(negedge clk);
        reset       = 1'b0;
        bus.end_lei = STDIN_STATUS;
        #1;
        checkOutput("status_in_reset", bus.saida, 32'h0);
        checkEco("eco_in_reset", 7'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("status_rst_edge6", bus.saida, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("status_rst_edge7", bus.saida, 32'h1);
        checkEco("eco_after_reset_push", 7'h23);
        repeat (3) @(negedge clk);
        bus.botao   = 1'b0;
        bus.end_lei = 32'h0;
        repeat (10) @(negedge clk);
        readRegister(STDIN_DADOS, 32'h23, "data_after_reset");
        readRegister(STDIN_STATUS, 32'h0, "status_final");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
